// File: rtl/btn_event_fsm.sv
// btn_event_fsm: classifies a debounced button level into press/release/short/long/double-click pulses.
// Optional auto-repeat while held is compiled in with `define REPEAT_EN.
module btn_event_fsm #(
  parameter int TICK_BITS    = 20,
  parameter int LONG_TICKS   = 100,
  parameter int DBL_TICKS    = 30,
  parameter int REPEAT_TICKS = 20,
  parameter int CNT_W        = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic db,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic held,
  output logic repeat_pulse
);
  typedef enum logic [2:0] {IDLE, PRESSED, LONG_HELD, WAIT_SECOND, SECOND_PRESSED} state_t;
  state_t state, nxt;
  logic db_q, rise, fall, m_tick;
  logic short_nxt, long_nxt, dbl_nxt, rep_nxt;
  logic [TICK_BITS-1:0] q;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  if (LONG_TICKS > 2**CNT_W || DBL_TICKS > 2**CNT_W || REPEAT_TICKS > 2**CNT_W) begin : g_cnt_w_check
    $error("CNT_W too narrow for tick thresholds");
  end
  assign rise   = db & ~db_q;
  assign fall   = ~db & db_q;
  assign m_tick = q == '0;
  // db edges are tested before m_tick in every state, so an edge wins a same-cycle tick
  always_comb begin
    nxt       = state;
    short_nxt = 1'b0;
    long_nxt  = 1'b0;
    dbl_nxt   = 1'b0;
    rep_nxt   = 1'b0;
    case (state)
      IDLE: if (rise) nxt = PRESSED;
      PRESSED:
        if (fall) nxt = WAIT_SECOND;
        else if (m_tick && cnt == CNT_W'(LONG_TICKS - 1)) begin
          nxt      = LONG_HELD;
          long_nxt = 1'b1;
        end
      LONG_HELD: begin
        if (fall) nxt = IDLE;
`ifdef REPEAT_EN
        else if (m_tick && cnt == CNT_W'(REPEAT_TICKS - 1)) rep_nxt = 1'b1;
`endif
      end
      WAIT_SECOND:
        if (rise) begin
          nxt     = SECOND_PRESSED;
          dbl_nxt = 1'b1;
        end else if (m_tick && cnt == CNT_W'(DBL_TICKS - 1)) begin
          nxt       = IDLE;
          short_nxt = 1'b1;
        end
      SECOND_PRESSED: if (fall) nxt = IDLE;
      default: nxt = IDLE;
    endcase
    cnt_nxt = (nxt != state || rep_nxt) ? '0 : (m_tick && cnt != '1) ? cnt + CNT_W'(1) : cnt;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state         <= IDLE;
      db_q          <= 1'b0;
      q             <= '0;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      double_click  <= 1'b0;
      held          <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      state         <= nxt;
      db_q          <= db;
      q             <= q + TICK_BITS'(1);
      cnt           <= cnt_nxt;
      press_pulse   <= rise;
      release_pulse <= fall;
      short_press   <= short_nxt;
      long_press    <= long_nxt;
      double_click  <= dbl_nxt;
      held          <= nxt == LONG_HELD;
      repeat_pulse  <= rep_nxt;
    end
endmodule

// File: tb/tb_btn_event_fsm.sv
// tb_btn_event_fsm: scoreboard bench for btn_event_fsm with a 16-cycle tick.
// Build with +define+REPEAT_EN to expect auto-repeat pulses while held.
module tb_btn_event_fsm;
  localparam int TICK = 16;
  localparam logic [5:0] PRESS = 6'b100000, REL = 6'b010000, SHORT = 6'b001000;
  localparam logic [5:0] LONG = 6'b000100, DBL = 6'b000010, REP = 6'b000001;
  typedef struct {int ev; logic [5:0] pl; logic hl;} ev_t;
  ev_t sb[$];
  logic clk = 1'b0, reset_n = 1'b0, db = 1'b0;
  logic press_pulse, release_pulse, short_press, long_press, double_click, held, repeat_pulse;
  logic exp_held = 1'b0;
  logic [5:0] exp_p, got_p;
  int edge_n, n_checks, n_fail;
  btn_event_fsm #(
    .TICK_BITS(4), .LONG_TICKS(4), .DBL_TICKS(2), .REPEAT_TICKS(2), .CNT_W(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .db(db),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .short_press(short_press),
    .long_press(long_press), .double_click(double_click), .held(held), .repeat_pulse(repeat_pulse)
  );
  always #5 clk = ~clk;
  // edge_n tracks the DUT prescaler: a tick is sampled at edges 1, 17, 33, ...
  always @(posedge clk or negedge reset_n)
    if (!reset_n) edge_n <= 0;
    else edge_n <= edge_n + 1;
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      exp_p = '0;
      if (sb.size() > 0 && sb[0].ev == edge_n) begin
        exp_p    = sb[0].pl;
        exp_held = sb[0].hl;
        void'(sb.pop_front());
      end
      got_p = {press_pulse, release_pulse, short_press, long_press, double_click, repeat_pulse};
      n_checks++;
      if ({got_p, held} !== {exp_p, exp_held}) begin
        n_fail++;
        $display("FAIL outputs @edge %0d: got press/rel/short/long/dbl/rep=%b held=%b, want %b held=%b",
                 edge_n, got_p, held, exp_p, exp_held);
      end
    end
  end
  initial begin
    #400000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end
  function automatic int nth_tick(input int e, input int n);
    return ((e - 1) / TICK + 1) * TICK + 1 + (n - 1) * TICK;
  endfunction
  task automatic push(input int e, input logic [5:0] p, input logic h);
    sb.push_back('{e, p, h});
  endtask
  // hi1 < 0 releases on the 4th tick edge plus adj; lo1 < 0 re-presses on the DBL window's last tick edge
  task automatic gesture(input int hi1, input int lo1, input int hi2, input int adj);
    int p, r, r2, s, t4;
    @(negedge clk);
    p  = edge_n + 1;
    t4 = nth_tick(p, 4);
    if (hi1 < 0) hi1 = t4 - p + adj;
    r  = p + hi1;
    db = 1'b1;
    push(p, PRESS, 1'b0);
    if (t4 < r) begin
      push(t4, LONG, 1'b1);
`ifdef REPEAT_EN
      for (int t = t4 + 2 * TICK; t < r; t += 2 * TICK) push(t, REP, 1'b1);
`endif
      push(r, REL, 1'b0);
    end else begin
      push(r, REL, 1'b0);
      s = nth_tick(r, 2);
      if (hi2 > 0) begin
        if (lo1 < 0) lo1 = s - r;
        r2 = r + lo1;
        push(r2, PRESS | DBL, 1'b0);
        push(r2 + hi2, REL, 1'b0);
      end else push(s, SHORT, 1'b0);
    end
    repeat (hi1) @(negedge clk);
    db = 1'b0;
    if (hi2 > 0) begin
      repeat (lo1) @(negedge clk);
      db = 1'b1;
      repeat (hi2) @(negedge clk);
      db = 1'b0;
    end
    for (int i = 0; i < 400 && sb.size() > 0; i++) @(negedge clk);
    repeat (80) @(negedge clk);
  endtask
  task automatic test_reset();
    reset_n = 1'b0;
    db = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({press_pulse, release_pulse, short_press, long_press, double_click, held, repeat_pulse} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_state: got %b want 0000000",
               {press_pulse, release_pulse, short_press, long_press, double_click, held, repeat_pulse});
    end
    reset_n = 1'b1;
    repeat (200) @(negedge clk);
    @(negedge clk);
    db = 1'b1;
    push(edge_n + 1, PRESS, 1'b0);
    repeat (20) @(negedge clk);
    reset_n  = 1'b0;
    db       = 1'b0;
    exp_held = 1'b0;
    #1;
    n_checks++;
    if ({press_pulse, release_pulse, short_press, long_press, double_click, held, repeat_pulse} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_async: got %b want 0000000",
               {press_pulse, release_pulse, short_press, long_press, double_click, held, repeat_pulse});
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (150) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL reset_abort: %0d events pending, want 0", sb.size());
      sb.delete();
    end
  endtask
  task automatic test_short();
    gesture(20, 0, 0, 0);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL short: %0d events unmatched, next at edge %0d, want 0", sb.size(), sb[0].ev);
      sb.delete();
    end
  endtask
  task automatic test_long(input int hold);
    gesture(hold, 0, 0, 0);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL long_%0d: %0d events unmatched, next at edge %0d, want 0", hold, sb.size(), sb[0].ev);
      sb.delete();
    end
  endtask
  task automatic test_double();
    gesture(20, 10, 20, 0);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL double: %0d events unmatched, next at edge %0d, want 0", sb.size(), sb[0].ev);
      sb.delete();
    end
  endtask
  task automatic test_fall_on_tick();
    gesture(-1, 0, 0, 0);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL fall_on_tick: %0d events unmatched, next at edge %0d, want 0", sb.size(), sb[0].ev);
      sb.delete();
    end
  endtask
  task automatic test_long_boundary();
    gesture(-1, 0, 0, 1);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL long_boundary: %0d events unmatched, next at edge %0d, want 0", sb.size(), sb[0].ev);
      sb.delete();
    end
  endtask
  task automatic test_double_boundary();
    gesture(20, -1, 20, 0);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL double_boundary: %0d events unmatched, next at edge %0d, want 0", sb.size(), sb[0].ev);
      sb.delete();
    end
  endtask
  initial begin
    test_reset();
    test_short();
    test_long(100);
    test_double();
    test_fall_on_tick();
    test_long_boundary();
    test_double_boundary();
    test_long(200);
    test_short();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
